pcie_quad_merge: RTL and testbench
==================================

// Module: pcie_quad_merge
// PURPOSE
//  Downstream of the quadrant read-enable generator. Takes the four DMA read FIFOs (A/B/C/D = TL/TR/BL/BR
//  of a 1920x1080 frame) and merges them into one raster-order pixel stream at pclk_div2.
//  Aligns the enables with FIFO read latency and adds SOF/EOL/EOF markers.
//  Also checks the quadrant sequence and counts FIFO underflows and completed frames.
// PARAMETERS
//  DATA_W   32    pixel/FIFO data width
//  H_ACT    1920  active pixels per line
//  V_ACT    1080  active lines per frame
//  H_SPLIT  960   first column of right quadrants (B/D)
//  V_SPLIT  540   first line of bottom quadrants (C/D)
//  RD_LAT   1     FIFO rden->dout latency in cycles (1..4)
// PORTS
//  pclk_div2            in   1       clock
//  sys_rst_n            in   1       async reset, active low
//  pcie_data_in_enable  in   1       stream enable; low = synchronous flush, position restart
//  dma_rd_X_rden        in   1       X=A..D, read enable issued to FIFO X
//  dma_rd_X_data        in   DATA_W  X=A..D, FIFO X dout
//  dma_rd_X_empty       in   1       X=A..D, FIFO X empty
//  pix_data             out  DATA_W  merged pixel
//  pix_valid            out  1       pix_data valid
//  pix_sof              out  1       with pix_valid: pixel (0,0)
//  pix_eol              out  1       with pix_valid: last pixel of a line (x=H_ACT-1)
//  pix_eof              out  1       with pix_valid: last pixel of frame (H_ACT-1,V_ACT-1)
//  underflow_cnt        out  16      saturating count of rden while empty
//  frame_cnt            out  16      wrapping count of completed frames (pix_eof beats)
//  quad_err             out  1       sticky: enable not one-hot, or wrong quadrant for position
// BEHAVIOUR
//  Reset: all outputs 0. Pipelines are cleared. Position counters are cleared.
//  Beat: cycle t where exactly one rden is high. Its {quadrant, empty} is captured into an RD_LAT-deep tag pipeline.
//  At t+RD_LAT the tag selects that FIFO's data. pix_data/pix_valid are registered and appear at t+RD_LAT+1.
//  Fixed latency RD_LAT+1, with no backpressure.
//  Underflow beat (rden & empty at t): underflow_cnt+1, saturating at 16'hFFFF.
//   The beat is still emitted with pix_data=0 and pix_valid=1, so raster position stays aligned.
//  Output position counters x (0..H_ACT-1) and y (0..V_ACT-1) advance on each emitted beat.
//   x wraps to 0 and y increments at x=H_ACT-1. At (H_ACT-1,V_ACT-1) both wrap to 0 and frame_cnt+1 (wraps).
//  Markers are combinational from x/y, qualified by pix_valid.
//  Quadrant check at the input: expected quadrant is A if (y_in<V_SPLIT, x_in<H_SPLIT), B/C/D likewise.
//   y_in/x_in is an input-side position pair that advances like x/y.
//   A mismatch, or more than one rden high in a cycle, sets quad_err. Only sys_rst_n clears quad_err.
//  Zero rden in a cycle: no beat, counters hold, pix_valid=0 RD_LAT+1 cycles later.
//  pcie_data_in_enable low: the tag pipeline is flushed (in-flight beats dropped) and pix_valid=0 next cycle.
//   x/y/x_in/y_in are cleared. underflow_cnt, frame_cnt and quad_err are held.
//   rden sampled while enable is low is ignored.
//  Enable rising mid-frame restarts at (0,0). No partial-frame EOF and no frame_cnt increment.
//  Async reset mid-operation: immediate return to reset values. No output glitch after deassert.
// STRUCTURE
//  Package pcie_video_pkg: H_ACT/V_ACT/H_SPLIT/V_SPLIT defaults, quadrant enum {QA,QB,QC,QD},
//   and a function quad_of(x,y).
//  Sub-module pcie_quad_tag_pipe: RD_LAT-deep {valid,quad[1:0],uf} shift register with sync flush.
//  Top: input checker, one tag pipe, 4:1 data mux + output register, x/y counters, stat counters.
// TESTING
//  1 Full frame, FIFO X preloaded with words 32'hX000_0000+n, correct enable order
//    -> 2073600 valid beats; pixel (959,0)=A data; (960,0)=B data; (0,540)=C data;
//       SOF at beat 0, EOL every 1920, EOF at beat 2073599; frame_cnt=1, quad_err=0.
//  2 Latency: single A rden at cycle 10 with RD_LAT=1 and RD_LAT=3
//    -> pix_valid exactly at cycle 12 and at cycle 14 respectively.
//  3 Underflow: B empty for 5 of its beats -> underflow_cnt=5; those 5 beats pix_data=0, valid=1;
//    line and frame markers unchanged.
//  4 Errors: A and C rden together in one cycle -> quad_err=1 and stays 1. B rden at x_in=0,y_in=0 -> quad_err=1.
//  5 Enable drop after 3000 beats with 2 beats in flight -> no valid from next cycle.
//    Re-enable -> first beat carries SOF, frame_cnt unchanged.
//  6 Force 65540 underflows -> underflow_cnt saturates at 16'hFFFF. Assert sys_rst_n mid-frame -> all outputs 0.

Source files
------------

// File: rtl/pcie_video_pkg.sv
// Shared video geometry defaults, quadrant encoding and read-tag layout for
// the PCIe quadrant merge path.
package pcie_video_pkg;

   localparam int unsigned H_ACT_DEF   = 1920;
   localparam int unsigned V_ACT_DEF   = 1080;
   localparam int unsigned H_SPLIT_DEF = 960;
   localparam int unsigned V_SPLIT_DEF = 540;

   typedef enum logic [1:0] {
      QA = 2'd0,
      QB = 2'd1,
      QC = 2'd2,
      QD = 2'd3
   } quad_e;

   typedef struct packed {
      logic  valid;
      quad_e quad;
      logic  uf;
   } tag_t;

   // Bit 1 selects bottom half, bit 0 selects right half.
   function automatic quad_e quad_of(input logic [15:0] x, input logic [15:0] y,
                                     input logic [15:0] h_split, input logic [15:0] v_split);
      quad_of = quad_e'({y >= v_split, x >= h_split});
   endfunction

endpackage

// File: rtl/pcie_quad_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligning each beat's quadrant and
// underflow flag with the FIFO read data. Synchronous flush drops all tags.
module pcie_quad_tag_pipe
   import pcie_video_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_flush,
   input  tag_t i_tag,
   output tag_t o_tag
);

   tag_t r_pipe [RD_LAT];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      end else if (i_flush) begin
         for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_tag;
         for (int unsigned i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/pcie_quad_merge.sv
// Merges four quadrant read FIFOs into one raster pixel stream with SOF/EOL/EOF
// markers, quadrant-order checking, underflow and frame statistics.
module pcie_quad_merge
   import pcie_video_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned H_ACT   = H_ACT_DEF,
   parameter int unsigned V_ACT   = V_ACT_DEF,
   parameter int unsigned H_SPLIT = H_SPLIT_DEF,
   parameter int unsigned V_SPLIT = V_SPLIT_DEF,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic              pclk_div2,
   input  logic              sys_rst_n,
   input  logic              pcie_data_in_enable,
   input  logic              dma_rd_A_rden,
   input  logic [DATA_W-1:0] dma_rd_A_data,
   input  logic              dma_rd_A_empty,
   input  logic              dma_rd_B_rden,
   input  logic [DATA_W-1:0] dma_rd_B_data,
   input  logic              dma_rd_B_empty,
   input  logic              dma_rd_C_rden,
   input  logic [DATA_W-1:0] dma_rd_C_data,
   input  logic              dma_rd_C_empty,
   input  logic              dma_rd_D_rden,
   input  logic [DATA_W-1:0] dma_rd_D_data,
   input  logic              dma_rd_D_empty,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic [15:0]       underflow_cnt,
   output logic [15:0]       frame_cnt,
   output logic              quad_err
);

   logic [3:0]        w_rden;
   logic              w_onehot, w_multi, w_beat, w_empty_sel, w_quad_bad;
   logic              w_x_last, w_y_last, w_xin_last, w_yin_last;
   quad_e             w_quad;
   tag_t              w_tag_in, w_tag_out;
   logic [DATA_W-1:0] w_mux;

   logic [DATA_W-1:0] r_pix_data;
   logic              r_pix_valid;
   logic [15:0]       r_x, r_y, r_x_in, r_y_in;
   logic [15:0]       r_underflow_cnt, r_frame_cnt;
   logic              r_quad_err;

   assign w_rden = {dma_rd_D_rden, dma_rd_C_rden, dma_rd_B_rden, dma_rd_A_rden};

   always_comb begin
      w_quad      = QA;
      w_empty_sel = 1'b0;
      case (w_rden)
         4'b0001: begin w_quad = QA; w_empty_sel = dma_rd_A_empty; end
         4'b0010: begin w_quad = QB; w_empty_sel = dma_rd_B_empty; end
         4'b0100: begin w_quad = QC; w_empty_sel = dma_rd_C_empty; end
         4'b1000: begin w_quad = QD; w_empty_sel = dma_rd_D_empty; end
         default: ;
      endcase
   end

   assign w_onehot   = (w_rden != 4'd0) && ((w_rden & (w_rden - 4'd1)) == 4'd0);
   assign w_multi    = (w_rden != 4'd0) && !w_onehot;
   assign w_beat     = pcie_data_in_enable && w_onehot;
   assign w_quad_bad = pcie_data_in_enable &&
                       (w_multi || (w_onehot &&
                        w_quad != quad_of(r_x_in, r_y_in, 16'(H_SPLIT), 16'(V_SPLIT))));

   assign w_tag_in = '{valid: w_beat, quad: w_quad, uf: w_beat & w_empty_sel};

   pcie_quad_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .i_clk   (pclk_div2),
      .i_rst_n (sys_rst_n),
      .i_flush (!pcie_data_in_enable),
      .i_tag   (w_tag_in),
      .o_tag   (w_tag_out)
   );

   always_comb begin
      w_mux = '0;
      case (w_tag_out.quad)
         QA: w_mux = dma_rd_A_data;
         QB: w_mux = dma_rd_B_data;
         QC: w_mux = dma_rd_C_data;
         QD: w_mux = dma_rd_D_data;
         default: ;
      endcase
   end

   // Underflow beats still occupy a raster slot, carried as zero data.
   always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
      end else if (!pcie_data_in_enable) begin
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
      end else begin
         r_pix_valid <= w_tag_out.valid;
         r_pix_data  <= (w_tag_out.valid && !w_tag_out.uf) ? w_mux : '0;
      end
   end

   assign w_x_last   = (r_x == 16'(H_ACT - 1));
   assign w_y_last   = (r_y == 16'(V_ACT - 1));
   assign w_xin_last = (r_x_in == 16'(H_ACT - 1));
   assign w_yin_last = (r_y_in == 16'(V_ACT - 1));

   // Output x/y track the pixel currently presented; input x/y track the next read.
   always_ff @(posedge pclk_div2 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_x             <= '0;
         r_y             <= '0;
         r_x_in          <= '0;
         r_y_in          <= '0;
         r_underflow_cnt <= '0;
         r_frame_cnt     <= '0;
         r_quad_err      <= 1'b0;
      end else if (!pcie_data_in_enable) begin
         r_x    <= '0;
         r_y    <= '0;
         r_x_in <= '0;
         r_y_in <= '0;
      end else begin
         if (r_pix_valid) begin
            if (w_x_last) begin
               r_x <= '0;
               if (w_y_last) begin
                  r_y         <= '0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
               end else begin
                  r_y <= r_y + 16'd1;
               end
            end else begin
               r_x <= r_x + 16'd1;
            end
         end
         if (w_beat) begin
            if (w_xin_last) begin
               r_x_in <= '0;
               r_y_in <= w_yin_last ? 16'd0 : r_y_in + 16'd1;
            end else begin
               r_x_in <= r_x_in + 16'd1;
            end
            if (w_empty_sel && r_underflow_cnt != 16'hFFFF)
               r_underflow_cnt <= r_underflow_cnt + 16'd1;
         end
         if (w_quad_bad) r_quad_err <= 1'b1;
      end
   end

   assign pix_data      = r_pix_data;
   assign pix_valid     = r_pix_valid;
   assign pix_sof       = r_pix_valid && (r_x == 16'd0) && (r_y == 16'd0);
   assign pix_eol       = r_pix_valid && w_x_last;
   assign pix_eof       = r_pix_valid && w_x_last && w_y_last;
   assign underflow_cnt = r_underflow_cnt;
   assign frame_cnt     = r_frame_cnt;
   assign quad_err      = r_quad_err;

endmodule

// File: tb/tb_pcie_quad_merge.sv
// Directed bench for pcie_quad_merge on a reduced 8x4 frame (split at 4,2),
// with a second instance at RD_LAT=3 for the latency case.
module tb_pcie_quad_merge;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int HS = 4;
   localparam int VS = 2;

   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [3:0]  rden, empty;
   logic [31:0] fdata [4];
   logic [31:0] fd1 [4];
   logic [31:0] fd2 [4];
   int unsigned fcnt [4];

   logic [31:0] p_data, p_data3;
   logic        p_valid, p_sof, p_eol, p_eof, qerr;
   logic        p_valid3, p_sof3, p_eol3, p_eof3, qerr3;
   logic [15:0] uf_cnt, fr_cnt, uf_cnt3, fr_cnt3;

   int n_checks = 0;
   int n_fail   = 0;
   int bx, by;
   logic [34:0] mon_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] base_of(input int q);
      return {4'(q + 10), 28'd0};
   endfunction

   // FIFO model: pops only when read while non-empty; dut3 sees the data 2 cycles later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int q = 0; q < 4; q++) begin
            fdata[q] <= '0; fd1[q] <= '0; fd2[q] <= '0; fcnt[q] <= 0;
         end
      end else begin
         for (int q = 0; q < 4; q++) begin
            if (rden[q] && !empty[q]) begin
               fdata[q] <= base_of(q) + 32'(fcnt[q]);
               fcnt[q]  <= fcnt[q] + 1;
            end
            fd1[q] <= fdata[q];
            fd2[q] <= fd1[q];
         end
      end
   end

   pcie_quad_merge #(
      .DATA_W(32), .H_ACT(H), .V_ACT(V), .H_SPLIT(HS), .V_SPLIT(VS), .RD_LAT(1)
   ) dut (
      .pclk_div2(clk), .sys_rst_n(rst_n), .pcie_data_in_enable(en),
      .dma_rd_A_rden(rden[0]), .dma_rd_A_data(fdata[0]), .dma_rd_A_empty(empty[0]),
      .dma_rd_B_rden(rden[1]), .dma_rd_B_data(fdata[1]), .dma_rd_B_empty(empty[1]),
      .dma_rd_C_rden(rden[2]), .dma_rd_C_data(fdata[2]), .dma_rd_C_empty(empty[2]),
      .dma_rd_D_rden(rden[3]), .dma_rd_D_data(fdata[3]), .dma_rd_D_empty(empty[3]),
      .pix_data(p_data), .pix_valid(p_valid), .pix_sof(p_sof), .pix_eol(p_eol),
      .pix_eof(p_eof), .underflow_cnt(uf_cnt), .frame_cnt(fr_cnt), .quad_err(qerr)
   );

   pcie_quad_merge #(
      .DATA_W(32), .H_ACT(H), .V_ACT(V), .H_SPLIT(HS), .V_SPLIT(VS), .RD_LAT(3)
   ) dut3 (
      .pclk_div2(clk), .sys_rst_n(rst_n), .pcie_data_in_enable(en),
      .dma_rd_A_rden(rden[0]), .dma_rd_A_data(fd2[0]), .dma_rd_A_empty(empty[0]),
      .dma_rd_B_rden(rden[1]), .dma_rd_B_data(fd2[1]), .dma_rd_B_empty(empty[1]),
      .dma_rd_C_rden(rden[2]), .dma_rd_C_data(fd2[2]), .dma_rd_C_empty(empty[2]),
      .dma_rd_D_rden(rden[3]), .dma_rd_D_data(fd2[3]), .dma_rd_D_empty(empty[3]),
      .pix_data(p_data3), .pix_valid(p_valid3), .pix_sof(p_sof3), .pix_eol(p_eol3),
      .pix_eof(p_eof3), .underflow_cnt(uf_cnt3), .frame_cnt(fr_cnt3), .quad_err(qerr3)
   );

   always @(negedge clk) begin
      if (p_valid) mon_q.push_back({p_sof, p_eol, p_eof, p_data});
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int count_bit(input int base, input int n, input int b);
      int c = 0;
      for (int i = 0; i < n; i++) if (mon_q[base+i][b]) c++;
      return c;
   endfunction

   function automatic int count_zero(input int base, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (mon_q[base+i][31:0] == 32'd0) c++;
      return c;
   endfunction

   // Issues n raster-ordered reads; the first b_uf B reads (or every read) see empty.
   task automatic send_beats(input int n, input int b_uf, input bit all_empty);
      int b_seen = 0;
      for (int i = 0; i < n; i++) begin
         int q;
         q = ((by >= VS) ? 2 : 0) + ((bx >= HS) ? 1 : 0);
         rden = '0;
         empty = '0;
         rden[q] = 1'b1;
         if (all_empty || (q == 1 && b_seen < b_uf)) empty[q] = 1'b1;
         if (q == 1) b_seen++;
         tick();
         bx++;
         if (bx == H) begin
            bx = 0;
            by++;
            if (by == V) by = 0;
         end
      end
      rden = '0;
      empty = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, first1, first3, n1, n3;
      logic [31:0] d1, d3;
      rst_n = 1'b0; en = 1'b0; rden = '0; empty = '0; bx = 0; by = 0;
      repeat (3) tick();
      check_val("rst_valid", 32'(p_valid), 32'd0);
      check_val("rst_data", p_data, 32'd0);
      check_val("rst_uf", 32'(uf_cnt), 32'd0);
      check_val("rst_frame", 32'(fr_cnt), 32'd0);
      check_val("rst_qerr", 32'(qerr), 32'd0);
      check_val("rst_valid3", 32'(p_valid3), 32'd0);
      rst_n = 1'b1; en = 1'b1;
      tick();

      // Full frame in correct quadrant order
      base = mon_q.size();
      send_beats(32, 0, 1'b0);
      repeat (8) tick();
      check_val("f1_beats", 32'(mon_q.size() - base), 32'd32);
      check_val("f1_sof0", 32'(mon_q[base][34]), 32'd1);
      check_val("f1_sof_cnt", 32'(count_bit(base, 32, 34)), 32'd1);
      check_val("f1_eol_cnt", 32'(count_bit(base, 32, 33)), 32'd4);
      check_val("f1_eol7", 32'(mon_q[base+7][33]), 32'd1);
      check_val("f1_eof31", 32'(mon_q[base+31][32]), 32'd1);
      check_val("f1_eof_cnt", 32'(count_bit(base, 32, 32)), 32'd1);
      check_val("f1_px3_0", mon_q[base+3][31:0], 32'hA000_0003);
      check_val("f1_px4_0", mon_q[base+4][31:0], 32'hB000_0000);
      check_val("f1_px0_1", mon_q[base+8][31:0], 32'hA000_0004);
      check_val("f1_px0_2", mon_q[base+16][31:0], 32'hC000_0000);
      check_val("f1_px7_3", mon_q[base+31][31:0], 32'hD000_0007);
      check_val("f1_frame", 32'(fr_cnt), 32'd1);
      check_val("f1_qerr", 32'(qerr), 32'd0);
      check_val("f1_uf", 32'(uf_cnt), 32'd0);

      // Latency: single A read, observe cycles 1..7 after it
      rden = 4'b0001;
      tick();
      rden = '0;
      first1 = -1; first3 = -1; n1 = 0; n3 = 0; d1 = '0; d3 = '0;
      for (int k = 1; k <= 7; k++) begin
         if (p_valid) begin
            n1++;
            if (first1 < 0) begin first1 = k; d1 = p_data; end
         end
         if (p_valid3) begin
            n3++;
            if (first3 < 0) begin first3 = k; d3 = p_data3; end
         end
         tick();
      end
      check_val("lat1_cycle", 32'(first1), 32'd2);
      check_val("lat3_cycle", 32'(first3), 32'd4);
      check_val("lat1_count", 32'(n1), 32'd1);
      check_val("lat3_count", 32'(n3), 32'd1);
      check_val("lat1_data", d1, 32'hA000_0008);
      check_val("lat3_data", d3, 32'hA000_0008);
      en = 1'b0;
      repeat (2) tick();
      check_val("restart_frame", 32'(fr_cnt), 32'd1);
      en = 1'b1; bx = 0; by = 0;
      tick();

      // Underflow on the first 5 B reads
      base = mon_q.size();
      send_beats(32, 5, 1'b0);
      repeat (4) tick();
      check_val("uf_beats", 32'(mon_q.size() - base), 32'd32);
      check_val("uf_cnt", 32'(uf_cnt), 32'd5);
      check_val("uf_zeros", 32'(count_zero(base, 32)), 32'd5);
      check_val("uf_px4_0", mon_q[base+4][31:0], 32'd0);
      check_val("uf_px4_1", mon_q[base+12][31:0], 32'd0);
      check_val("uf_px5_1", mon_q[base+13][31:0], 32'hB000_0008);
      check_val("uf_sof0", 32'(mon_q[base][34]), 32'd1);
      check_val("uf_eol_cnt", 32'(count_bit(base, 32, 33)), 32'd4);
      check_val("uf_eof31", 32'(mon_q[base+31][32]), 32'd1);
      check_val("uf_frame", 32'(fr_cnt), 32'd2);

      // Quadrant errors
      base = mon_q.size();
      rden = 4'b0101;
      tick();
      rden = '0;
      repeat (3) tick();
      check_val("err_multi", 32'(qerr), 32'd1);
      check_val("err_multi_nobeat", 32'(mon_q.size() - base), 32'd0);
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      check_val("err_sticky", 32'(qerr), 32'd1);
      check_val("en_hold_uf", 32'(uf_cnt), 32'd5);
      check_val("en_hold_frame", 32'(fr_cnt), 32'd2);
      rst_n = 1'b0;
      tick();
      check_val("rst2_valid", 32'(p_valid), 32'd0);
      check_val("rst2_uf", 32'(uf_cnt), 32'd0);
      check_val("rst2_frame", 32'(fr_cnt), 32'd0);
      check_val("rst2_qerr", 32'(qerr), 32'd0);
      rst_n = 1'b1;
      tick();
      rden = 4'b0010;
      tick();
      rden = '0;
      repeat (3) tick();
      check_val("err_wrong_quad", 32'(qerr), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; bx = 0; by = 0;
      tick();

      // Enable drop mid-frame with beats in flight, then restart
      base = mon_q.size();
      send_beats(20, 0, 1'b0);
      en = 1'b0;
      rden = 4'b0001;
      tick();
      rden = '0;
      check_val("drop_next", 32'(p_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val("drop_idle", 32'(p_valid), 32'd0);
      end
      check_val("drop_beats", 32'(mon_q.size() - base), 32'd19);
      check_val("drop_no_eof", 32'(count_bit(base, 19, 32)), 32'd0);
      check_val("drop_frame", 32'(fr_cnt), 32'd0);
      en = 1'b1; bx = 0; by = 0;
      base = mon_q.size();
      send_beats(32, 0, 1'b0);
      repeat (4) tick();
      check_val("reen_beats", 32'(mon_q.size() - base), 32'd32);
      check_val("reen_sof", 32'(mon_q[base][34]), 32'd1);
      check_val("reen_eof", 32'(mon_q[base+31][32]), 32'd1);
      check_val("reen_frame", 32'(fr_cnt), 32'd1);
      check_val("reen_qerr", 32'(qerr), 32'd0);

      // Underflow saturation, then async reset mid-frame
      send_beats(65535, 0, 1'b1);
      tick();
      check_val("sat_65535", 32'(uf_cnt), 32'h0000_FFFF);
      send_beats(5, 0, 1'b1);
      repeat (3) tick();
      check_val("sat_65540", 32'(uf_cnt), 32'h0000_FFFF);
      check_val("sat_frame", 32'(fr_cnt), 32'd2049);
      send_beats(3, 0, 1'b1);
      check_val("arst_pre_valid", 32'(p_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_valid", 32'(p_valid), 32'd0);
      check_val("arst_data", p_data, 32'd0);
      check_val("arst_uf", 32'(uf_cnt), 32'd0);
      check_val("arst_frame", 32'(fr_cnt), 32'd0);
      check_val("arst_qerr", 32'(qerr), 32'd0);
      #2 rst_n = 1'b1;
      repeat (2) tick();
      check_val("arst_post_valid", 32'(p_valid), 32'd0);
      check_val("arst_post_uf", 32'(uf_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
